// File: rtl/priv_1_12_trap_ctrl.sv
// Trap entry/exit sequencer: captures a trap or MRET, holds the pipeline until drained,
// commits the CSR updates, then redirects fetch. Optional macro: PRIV_VECTORED_MTVEC_EN.
module priv_1_12_trap_ctrl #(
    parameter int SUPPORT_U     = 1,
    parameter int DRAIN_TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic        intr_req,
    input  logic [3:0]  intr_cause,
    input  logic        mret_req,
    input  logic [31:0] epc,
    input  logic        pipe_drained,
    input  logic [1:0]  curr_priv,
    input  logic        mie,
    input  logic        mpie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        flush_req,
    output logic        busy,
    output logic        trap_commit,
    output logic        mret_commit,
    output logic        mstatus_we,
    output logic        mie_next,
    output logic        mpie_next,
    output logic [1:0]  mpp_next,
    output logic        mepc_we,
    output logic [31:0] mepc_wdata,
    output logic        mcause_we,
    output logic [31:0] mcause_wdata,
    output logic        mtval_we,
    output logic [31:0] mtval_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT  = 32'(DRAIN_TIMEOUT);
    localparam logic [1:0]  MRET_MPP = (SUPPORT_U != 0) ? 2'b00 : 2'b11;

    state_t      state_reg, state_next;
    logic        is_mret_reg, is_mret_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] tval_reg, tval_next;
    logic [31:0] pc_reg, pc_next;
    logic [1:0]  priv_reg, priv_next;
    logic [31:0] drain_cnt_reg, drain_cnt_next;
    logic        drain_err_reg, drain_err_next;
    logic [31:0] drain_cnt_inc;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            is_mret_reg   <= 1'b0;
            cause_reg     <= 32'd0;
            tval_reg      <= 32'd0;
            pc_reg        <= 32'd0;
            priv_reg      <= 2'b00;
            drain_cnt_reg <= 32'd0;
            drain_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            is_mret_reg   <= is_mret_next;
            cause_reg     <= cause_next;
            tval_reg      <= tval_next;
            pc_reg        <= pc_next;
            priv_reg      <= priv_next;
            drain_cnt_reg <= drain_cnt_next;
            drain_err_reg <= drain_err_next;
        end
    end

    // Saturating so a very long drain never wraps back under the timeout.
    assign drain_cnt_inc = (&drain_cnt_reg) ? drain_cnt_reg : drain_cnt_reg + 32'd1;

    always_comb begin
        state_next     = state_reg;
        is_mret_next   = is_mret_reg;
        cause_next     = cause_reg;
        tval_next      = tval_reg;
        pc_next        = pc_reg;
        priv_next      = priv_reg;
        drain_cnt_next = drain_cnt_reg;
        drain_err_next = drain_err_reg;

        case (state_reg)
            IDLE: begin
                drain_cnt_next = 32'd0;
                if (intr_req || exc_req || mret_req) begin
                    state_next = DRAIN;
                    pc_next    = epc;
                    priv_next  = curr_priv;
                    if (intr_req) begin
                        is_mret_next = 1'b0;
                        cause_next   = {1'b1, 27'd0, intr_cause};
                        tval_next    = 32'd0;
                    end else if (exc_req) begin
                        is_mret_next = 1'b0;
                        cause_next   = {28'd0, exc_cause};
                        tval_next    = exc_tval;
                    end else if (curr_priv == 2'b11) begin
                        is_mret_next = 1'b1;
                        cause_next   = 32'd0;
                        tval_next    = 32'd0;
                    end else begin
                        // MRET below M-mode is an illegal instruction.
                        is_mret_next = 1'b0;
                        cause_next   = 32'd2;
                        tval_next    = 32'd0;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_next = drain_cnt_inc;
                if ((TIMEOUT != 32'd0) && (drain_cnt_inc >= TIMEOUT)) begin
                    drain_err_next = 1'b1;
                end
                if (pipe_drained) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = REDIRECT;
            end
            REDIRECT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign trap_base = {mtvec[31:2], 2'b00};

`ifdef PRIV_VECTORED_MTVEC_EN
    assign trap_target = (cause_reg[31] && (mtvec[1:0] == 2'b01))
                       ? trap_base + {26'd0, cause_reg[3:0], 2'b00}
                       : trap_base;
`else
    assign trap_target = trap_base;
`endif

    always_comb begin
        flush_req      = 1'b0;
        busy           = 1'b0;
        trap_commit    = 1'b0;
        mret_commit    = 1'b0;
        mstatus_we     = 1'b0;
        mie_next       = 1'b0;
        mpie_next      = 1'b0;
        mpp_next       = 2'b00;
        mepc_we        = 1'b0;
        mepc_wdata     = 32'd0;
        mcause_we      = 1'b0;
        mcause_wdata   = 32'd0;
        mtval_we       = 1'b0;
        mtval_wdata    = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (state_reg)
            DRAIN: begin
                flush_req = 1'b1;
                busy      = 1'b1;
            end
            COMMIT: begin
                flush_req  = 1'b1;
                busy       = 1'b1;
                mstatus_we = 1'b1;
                if (is_mret_reg) begin
                    mie_next    = mpie;
                    mpie_next   = 1'b1;
                    mpp_next    = MRET_MPP;
                    mret_commit = 1'b1;
                end else begin
                    mie_next     = 1'b0;
                    mpie_next    = mie;
                    mpp_next     = priv_reg;
                    trap_commit  = 1'b1;
                    mepc_we      = 1'b1;
                    mepc_wdata   = {pc_reg[31:2], 2'b00};
                    mcause_we    = 1'b1;
                    mcause_wdata = cause_reg;
                    mtval_we     = 1'b1;
                    mtval_wdata  = tval_reg;
                end
            end
            REDIRECT: begin
                flush_req      = 1'b1;
                busy           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = is_mret_reg ? mepc : trap_target;
            end
            default: begin
            end
        endcase
    end

    assign drain_err = drain_err_reg;

endmodule
